// File: rtl/mmd_pkg.sv
// Shared MMD datapath constants and the byte-packer state type.
package mmd_pkg;

  localparam int unsigned MMD_BYTE_W    = 8;
  localparam int unsigned MMD_NUM_SLOTS = 16;
  localparam int unsigned MMD_SEL_W     = 4;
  localparam int unsigned MMD_WORD_W    = 128;

  typedef enum logic {
    PK_FILL,
    PK_HOLD
  } packer_state_t;

endpackage

// File: rtl/byte_slot_decoder.sv
// Slot pointer + write strobe -> one-hot slot write enables (inverse of the 16:1 byte read mux).
module byte_slot_decoder
  import mmd_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = MMD_NUM_SLOTS,
  parameter int unsigned SEL_W     = $clog2(NUM_SLOTS)
) (
  input  logic [SEL_W-1:0]     sel_i,
  input  logic                 wr_en_i,
  output logic [NUM_SLOTS-1:0] slot_en_o
);

  always_comb begin
    slot_en_o = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (wr_en_i && (sel_i == SEL_W'(k))) begin
        slot_en_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_packer_1to16.sv
// Serial-to-parallel byte packer: 16 handshaked bytes -> one 128-bit word with valid/ready.
// Optional partial-word flush and out_count port: define BYTE_PACKER_FLUSH_EN.
module byte_packer_1to16
  import mmd_pkg::*;
#(
  parameter int unsigned BYTE_W    = MMD_BYTE_W,
  parameter int unsigned NUM_SLOTS = MMD_NUM_SLOTS,
  parameter int unsigned SEL_W     = $clog2(NUM_SLOTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BYTE_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [BYTE_W*NUM_SLOTS-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready
`ifdef BYTE_PACKER_FLUSH_EN
  ,
  input  logic                        flush,
  output logic [SEL_W:0]              out_count
`endif
);

  localparam logic [SEL_W-1:0] LAST_PTR = SEL_W'(NUM_SLOTS - 1);

  packer_state_t                state_q, state_d;
  logic [SEL_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [BYTE_W*NUM_SLOTS-1:0]  word_q, word_d;
  logic [NUM_SLOTS-1:0]         slot_en;
  logic                         accept;
  logic                         flush_close;
  logic                         close_word;
  logic                         handoff;

  assign accept  = in_valid & (state_q == PK_FILL);
  assign handoff = out_ready & (state_q == PK_HOLD);

`ifdef BYTE_PACKER_FLUSH_EN
  // A flush only closes the word when it would hold at least one byte after this edge.
  assign flush_close = flush & (state_q == PK_FILL) & (accept | (wr_ptr_q != '0));
`else
  assign flush_close = 1'b0;
`endif

  assign close_word = (accept & (wr_ptr_q == LAST_PTR)) | flush_close;

  byte_slot_decoder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SEL_W     (SEL_W)
  ) u_slot_dec (
    .sel_i     (wr_ptr_q),
    .wr_en_i   (accept),
    .slot_en_o (slot_en)
  );

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    word_d    = word_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      PK_FILL: begin
        in_ready = 1'b1;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
          if (slot_en[k]) begin
            word_d[k*BYTE_W +: BYTE_W] = in_data;
          end
        end
        if (accept) begin
          wr_ptr_d = wr_ptr_q + SEL_W'(1);
        end
        if (close_word) begin
          wr_ptr_d = '0;
          state_d  = PK_HOLD;
        end
      end
      PK_HOLD: begin
        out_valid = 1'b1;
        // Clearing on handoff keeps never-written slots of the next word at zero.
        if (out_ready) begin
          word_d  = '0;
          state_d = PK_FILL;
        end
      end
      default: begin
        state_d  = PK_FILL;
        wr_ptr_d = '0;
        word_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PK_FILL;
      wr_ptr_q <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      word_q   <= word_d;
    end
  end

  assign out_data = word_q;

`ifdef BYTE_PACKER_FLUSH_EN
  logic [SEL_W:0] count_q, count_d;

  // Byte count of the closing word: bytes already held plus the one landing this cycle.
  always_comb begin
    count_d = count_q;
    if (close_word) begin
      count_d = {1'b0, wr_ptr_q} + {{SEL_W{1'b0}}, accept};
    end else if (handoff) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`else
  logic unused_handoff;
  assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_byte_packer_1to16.sv
// Self-checking bench for byte_packer_1to16: vector table + scoreboard of expected words.
module tb_byte_packer_1to16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
`ifdef BYTE_PACKER_FLUSH_EN
  logic         flush = 1'b0;
  logic [4:0]   out_count;
`endif

  always #5 clk = ~clk;

  byte_packer_1to16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef BYTE_PACKER_FLUSH_EN
    ,
    .flush     (flush),
    .out_count (out_count)
`endif
  );

  typedef struct {
    logic [127:0] word;
    int unsigned  cnt;
  } exp_t;

  typedef struct {
    logic [7:0]   base;
    bit           gaps;
    logic [127:0] word;
  } vec_t;

  exp_t        sb[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned n_words = 0;
  bit          m_hold = 1'b0;
  int unsigned m_ptr = 0;
  bit          m_acc = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference handshake model; compares flags every cycle and words at handoff.
  always @(negedge clk) begin
    m_acc = 1'b0;
    if (rst) begin
      m_hold = 1'b0;
      m_ptr  = 0;
    end else begin
      check("in_ready", in_ready, !m_hold);
      check("out_valid", out_valid, m_hold);
      if (m_hold) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 1'b1, 1'b0);
        end else begin
          check("out_data", out_data, sb[0].word);
`ifdef BYTE_PACKER_FLUSH_EN
          check("out_count", out_count, sb[0].cnt);
`endif
        end
        if (out_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          n_words++;
          m_hold = 1'b0;
        end
      end else begin
        if (in_valid) begin
          m_acc = 1'b1;
          m_ptr++;
        end
`ifdef BYTE_PACKER_FLUSH_EN
        if (flush && m_ptr != 0) m_ptr = 16;
`endif
        if (m_ptr == 16) begin
          m_ptr  = 0;
          m_hold = 1'b1;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit fl);
    int unsigned t;
    t = 0;
    in_data  = d;
    in_valid = 1'b1;
`ifdef BYTE_PACKER_FLUSH_EN
    flush = fl;
`else
    if (fl) check("flush_unsupported", 1'b1, 1'b0);
`endif
    do begin
      @(posedge clk); #1;
      t++;
    end while (!m_acc && t < 60);
    if (!m_acc) check("accept_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
`ifdef BYTE_PACKER_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic send_word(input logic [7:0] base, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_byte(base + 8'(i), 1'b0);
    end
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while ((sb.size() != 0 || m_hold) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", (sb.size() == 0 && !m_hold), 1'b1);
  endtask

  task automatic push(input logic [127:0] w, input int unsigned c);
    exp_t e;
    e.word = w;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[4];
    int unsigned w0;

    tbl[0] = '{8'h00, 1'b0, 128'h0F0E0D0C0B0A09080706050403020100};
    tbl[1] = '{8'hA0, 1'b0, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0};
    tbl[2] = '{8'hA0, 1'b1, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0};
    tbl[3] = '{8'h10, 1'b1, 128'h1F1E1D1C1B1A19181716151413121110};

    // Reset values while reset is held.
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Async reset mid-cycle while a full word is pending.
    out_ready = 1'b0;
    push(128'h3F3E3D3C3B3A39383736353433323130, 16);
    send_word(8'h30, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_in_ready", in_ready, 1'b1);
    check("async_out_data", out_data, '0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Table: full words, back-to-back and with input gaps.
    for (int v = 0; v < 4; v++) begin
      push(tbl[v].word, 16);
      send_word(tbl[v].base, tbl[v].gaps);
      if (v == 0) begin
        @(posedge clk);
        @(negedge clk);
        check("cleared_data", out_data, '0);
        check("cleared_valid", out_valid, 1'b0);
      end
      drain();
    end

    // Backpressure: held word stays put, pending byte FF is not consumed.
    out_ready = 1'b0;
    push(128'h3F3E3D3C3B3A39383736353433323130, 16);
    send_word(8'h30, 1'b0);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    push(128'h0F0E0D0C0B0A090807060504030201FF, 16);
    out_ready = 1'b1;
    send_byte(8'hFF, 1'b0);
    for (int i = 1; i < 16; i++) send_byte(8'(i), 1'b0);
    drain();

    // Reset mid-word discards the partial bytes.
    w0 = n_words;
    for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i), 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push(128'h1F1E1D1C1B1A19181716151413121110, 16);
    send_word(8'h10, 1'b0);
    drain();
    check("reset_one_word", n_words - w0, 1);

`ifdef BYTE_PACKER_FLUSH_EN
    push(128'h0000_0000_0000_0000_0000_0000_00CC_BBAA, 3);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    drain();

    w0 = n_words;
    flush = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("flush_empty_no_word", n_words - w0, 0);

    push(128'h4F4E4D4C4B4A49484746454443424140, 16);
    for (int i = 0; i < 15; i++) send_byte(8'h40 + 8'(i), 1'b0);
    send_byte(8'h4F, 1'b1);
    drain();
`endif

    repeat (3) begin @(posedge clk); #1; end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
